// File: rtl/bp_axi4_lite_to_bedrock.sv
// rtl/bp_axi4_lite_to_bedrock.sv - AXI4-Lite subordinate bridging single-beat reads/writes to BedRock IO uncached commands.
// Optional response timeout: define BP_AXIL_TIMEOUT_EN.
module bp_axi4_lite_to_bedrock
  #(parameter int paddr_width_p = 40
   ,parameter int lce_id_width_p = 8
   ,parameter int axi_addr_width_p = 28
   ,parameter int axi_data_width_p = 64
   ,parameter int axi_wstrb_width_p = axi_data_width_p/8
   ,parameter logic [paddr_width_p-1:0] base_addr_p = '0
   ,parameter int timeout_cycles_p = 1024
   ,localparam int dword_width_gp = 64
   ,localparam int io_mem_msg_header_width_lp = lce_id_width_p + 8 + 3 + paddr_width_p + 8
  )
  (input  logic                                  clk_i
  ,input  logic                                  reset_n_i
  ,input  logic [axi_addr_width_p-1:0]           awaddr_i
  ,input  logic [2:0]                            awprot_i
  ,input  logic                                  awvalid_i
  ,output logic                                  awready_o
  ,input  logic [axi_data_width_p-1:0]           wdata_i
  ,input  logic [axi_wstrb_width_p-1:0]          wstrb_i
  ,input  logic                                  wvalid_i
  ,output logic                                  wready_o
  ,output logic [1:0]                            bresp_o
  ,output logic                                  bvalid_o
  ,input  logic                                  bready_i
  ,input  logic [axi_addr_width_p-1:0]           araddr_i
  ,input  logic [2:0]                            arprot_i
  ,input  logic                                  arvalid_i
  ,output logic                                  arready_o
  ,output logic [axi_data_width_p-1:0]           rdata_o
  ,output logic [1:0]                            rresp_o
  ,output logic                                  rvalid_o
  ,input  logic                                  rready_i
  ,output logic [io_mem_msg_header_width_lp-1:0] io_cmd_header_o
  ,output logic [dword_width_gp-1:0]             io_cmd_data_o
  ,output logic                                  io_cmd_v_o
  ,input  logic                                  io_cmd_ready_and_i
  ,output logic                                  io_cmd_last_o
  ,input  logic [io_mem_msg_header_width_lp-1:0] io_resp_header_i
  ,input  logic [dword_width_gp-1:0]             io_resp_data_i
  ,input  logic                                  io_resp_v_i
  ,output logic                                  io_resp_yumi_o
  ,input  logic                                  io_resp_last_i
  );

  localparam logic [3:0] e_uc_rd = 4'd2;
  localparam logic [3:0] e_uc_wr = 4'd3;

  typedef enum logic [2:0] {e_ready, e_send_cmd, e_wait_resp, e_send_r, e_send_b} state_e;
  state_e state_q;

  logic aw_full_q, aw_full_d, w_full_q, w_full_d, awready_q, wready_q, rr_q;
  logic [axi_addr_width_p-4:0]  awaddr_q;
  logic [axi_data_width_p-1:0]  wdata_q;
  logic [axi_wstrb_width_p-1:0] wstrb_q;
  logic                         is_read_q, cmd_v_q, rvalid_q, bvalid_q;
  logic [3:0]                   msg_q;
  logic [2:0]                   size_q, off_q;
  logic [paddr_width_p-1:0]     addr_q;
  logic [dword_width_gp-1:0]    data_q, rdata_q;
  logic [1:0]                   bresp_q, rresp_q;

  logic wr_pend, ar_grant, w_grant, st_ok, resp_take;
  logic [2:0] st_size, st_off;
  logic [63:0] st_shift, st_data;
  logic [1:0] resp_code;
  logic unused;

  // Strobe decode: only naturally aligned power-of-two runs map onto a BedRock size.
  always_comb begin
    st_ok = 1'b1;
    st_size = 3'd3;
    st_off = 3'd0;
    case (wstrb_q)
      8'hFF: ;
      8'h0F: st_size = 3'd2;
      8'hF0: begin st_size = 3'd2; st_off = 3'd4; end
      8'h03: st_size = 3'd1;
      8'h0C: begin st_size = 3'd1; st_off = 3'd2; end
      8'h30: begin st_size = 3'd1; st_off = 3'd4; end
      8'hC0: begin st_size = 3'd1; st_off = 3'd6; end
      8'h01: st_size = 3'd0;
      8'h02: begin st_size = 3'd0; st_off = 3'd1; end
      8'h04: begin st_size = 3'd0; st_off = 3'd2; end
      8'h08: begin st_size = 3'd0; st_off = 3'd3; end
      8'h10: begin st_size = 3'd0; st_off = 3'd4; end
      8'h20: begin st_size = 3'd0; st_off = 3'd5; end
      8'h40: begin st_size = 3'd0; st_off = 3'd6; end
      8'h80: begin st_size = 3'd0; st_off = 3'd7; end
      default: st_ok = 1'b0;
    endcase
    st_shift = wdata_q >> {st_off, 3'b000};
    case (st_size)
      3'd0:    st_data = {8{st_shift[7:0]}};
      3'd1:    st_data = {4{st_shift[15:0]}};
      3'd2:    st_data = {2{st_shift[31:0]}};
      default: st_data = st_shift;
    endcase
  end

  assign wr_pend   = aw_full_q & w_full_q;
  assign ar_grant  = (state_q == e_ready) & arvalid_i & (~wr_pend | ~rr_q);
  assign w_grant   = (state_q == e_ready) & wr_pend & (~arvalid_i | rr_q);
  assign aw_full_d = (aw_full_q | (awvalid_i & awready_q)) & ~w_grant;
  assign w_full_d  = (w_full_q | (wvalid_i & wready_q)) & ~w_grant;
  assign resp_code = (io_resp_header_i[3:0] != msg_q) ? 2'b10 : 2'b00;

  assign awready_o       = awready_q;
  assign wready_o        = wready_q;
  assign arready_o       = ar_grant;
  assign bvalid_o        = bvalid_q;
  assign bresp_o         = bresp_q;
  assign rvalid_o        = rvalid_q;
  assign rresp_o         = rresp_q;
  assign rdata_o         = rdata_q;
  assign io_cmd_v_o      = cmd_v_q;
  assign io_cmd_last_o   = cmd_v_q;
  assign io_cmd_data_o   = data_q;
  assign io_cmd_header_o = {{(lce_id_width_p+8){1'b0}}, size_q, addr_q, 4'b0000, msg_q};
  assign unused = ^{awprot_i, arprot_i, io_resp_last_i, io_resp_header_i[io_mem_msg_header_width_lp-1:4]};

`ifdef BP_AXIL_TIMEOUT_EN
  localparam int cnt_w_lp = $clog2(timeout_cycles_p + 1);
  logic [cnt_w_lp-1:0] cnt_q;
  logic drop_q;
  // A stale response after a timeout is swallowed in whatever state it turns up.
  assign resp_take      = io_resp_v_i & ~drop_q;
  assign io_resp_yumi_o = io_resp_v_i & ((state_q == e_wait_resp) | drop_q);
`else
  assign resp_take      = io_resp_v_i;
  assign io_resp_yumi_o = io_resp_v_i & (state_q == e_wait_resp);
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_ready;
      aw_full_q <= 1'b0; w_full_q <= 1'b0; awready_q <= 1'b0; wready_q <= 1'b0; rr_q <= 1'b0;
      awaddr_q <= '0; wdata_q <= '0; wstrb_q <= '0;
      is_read_q <= 1'b0; cmd_v_q <= 1'b0; rvalid_q <= 1'b0; bvalid_q <= 1'b0;
      msg_q <= '0; size_q <= '0; off_q <= '0; addr_q <= '0; data_q <= '0; rdata_q <= '0;
      bresp_q <= '0; rresp_q <= '0;
`ifdef BP_AXIL_TIMEOUT_EN
      cnt_q <= '0; drop_q <= 1'b0;
`endif
    end else begin
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      awready_q <= ~aw_full_d;
      wready_q  <= ~w_full_d;
      if (awvalid_i & awready_q) awaddr_q <= awaddr_i[axi_addr_width_p-1:3];
      if (wvalid_i & wready_q) begin wdata_q <= wdata_i; wstrb_q <= wstrb_i; end
`ifdef BP_AXIL_TIMEOUT_EN
      if (drop_q & io_resp_v_i) drop_q <= 1'b0;
`endif
      case (state_q)
        e_ready: begin
          if (ar_grant) begin
            rr_q <= ~rr_q; is_read_q <= 1'b1; msg_q <= e_uc_rd; size_q <= 3'd3;
            addr_q <= base_addr_p + paddr_width_p'(araddr_i); off_q <= araddr_i[2:0];
            data_q <= '0; cmd_v_q <= 1'b1; state_q <= e_send_cmd;
          end else if (w_grant) begin
            rr_q <= ~rr_q; is_read_q <= 1'b0;
            if (st_ok) begin
              msg_q <= e_uc_wr; size_q <= st_size; off_q <= st_off; data_q <= st_data;
              addr_q <= base_addr_p + paddr_width_p'({awaddr_q, st_off});
              cmd_v_q <= 1'b1; state_q <= e_send_cmd;
            end else begin
              bresp_q <= 2'b10; bvalid_q <= 1'b1; state_q <= e_send_b;
            end
          end
        end
        e_send_cmd: if (io_cmd_ready_and_i) begin
          cmd_v_q <= 1'b0; state_q <= e_wait_resp;
`ifdef BP_AXIL_TIMEOUT_EN
          cnt_q <= '0;
`endif
        end
        e_wait_resp: begin
          if (resp_take) begin
            rdata_q <= io_resp_data_i << {off_q, 3'b000};
            if (is_read_q) begin rvalid_q <= 1'b1; rresp_q <= resp_code; state_q <= e_send_r; end
            else begin bvalid_q <= 1'b1; bresp_q <= resp_code; state_q <= e_send_b; end
          end
`ifdef BP_AXIL_TIMEOUT_EN
          else if (cnt_q == cnt_w_lp'(timeout_cycles_p - 1)) begin
            drop_q <= 1'b1; rdata_q <= '0;
            if (is_read_q) begin rvalid_q <= 1'b1; rresp_q <= 2'b11; state_q <= e_send_r; end
            else begin bvalid_q <= 1'b1; bresp_q <= 2'b11; state_q <= e_send_b; end
          end else cnt_q <= cnt_q + 1'b1;
`endif
        end
        e_send_r: if (rready_i) begin rvalid_q <= 1'b0; state_q <= e_ready; end
        e_send_b: if (bready_i) begin bvalid_q <= 1'b0; state_q <= e_ready; end
        default: state_q <= e_ready;
      endcase
    end
  end

endmodule
